weight_load_ctrl: RTL

Sequences the loading of one layer's convolution weights from a 64-bit valid/ready/last stream into the conv engine's on-chip weight buffer. Software/top-level FSM issues a start with the layer's beat count and buffer base address; the block accepts exactly that many beats, writes them to consecutive buffer addresses, and reports completion or a length mismatch. It sits between the weight DMA/stream source and the weight buffer, one instance per conv engine.

---
 rtl/weight_load_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/weight_load_ctrl.sv
// Weight-load sequencer: moves one layer's weights from a valid/ready/last
// stream into consecutive weight-buffer addresses and flags length mismatches.
module weight_load_ctrl #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 16
) (
   input  logic              sclk,
   input  logic              s_rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  cfg_beats,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   output logic              busy,
   output logic              done,
   output logic              err_len,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   input  logic              buf_ready,
   output logic              buf_wr_en,
   output logic [ADDR_W-1:0] buf_wr_addr,
   output logic [DATA_W-1:0] buf_wr_data
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  beats_q, beats_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              busy_q, done_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;

   logic              ready_s;
   logic              accept_s;
   logic              last_cnt_s;
   logic              wr_en_s;

   // Stream ready: follows buffer space while loading, always open while draining
   always_comb begin
      case (state_q)
         ST_LOAD:  ready_s = buf_ready;
         ST_DRAIN: ready_s = 1'b1;
         default:  ready_s = 1'b0;
      endcase
   end

   assign accept_s   = s_valid & ready_s;
   assign last_cnt_s = (cnt_q == (beats_q - CNT_ONE));
   assign wr_en_s    = accept_s & (state_q == ST_LOAD);

   // Next-state, counter and length-error bookkeeping
   always_comb begin
      state_d = state_q;
      beats_d = beats_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               beats_d = cfg_beats;
               base_d  = cfg_base_addr;
               cnt_d   = CNT_ZERO;
               err_d   = 1'b0;
               if (cfg_beats != CNT_ZERO) begin
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (accept_s) begin
               cnt_d = cnt_q + CNT_ONE;
               if (s_last) begin
                  // A last marker before the expected final beat is a short stream
                  state_d = ST_DONE;
                  if (!last_cnt_s) begin
                     err_d = 1'b1;
                  end else begin
                     err_d = err_q;
                  end
               end else if (last_cnt_s) begin
                  err_d   = 1'b1;
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_DRAIN: begin
            if (accept_s && s_last) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state and registered status outputs
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q <= ST_IDLE;
         beats_q <= CNT_ZERO;
         base_q  <= {ADDR_W{1'b0}};
         cnt_q   <= CNT_ZERO;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beats_q <= beats_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_d == ST_DONE);
      end
   end

   // Buffer write port: one-cycle registered copy of each accepted load beat
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= {ADDR_W{1'b0}};
         wr_data_q <= {DATA_W{1'b0}};
      end else begin
         wr_en_q <= wr_en_s;
         if (wr_en_s) begin
            // Address wraps modulo the buffer size by truncation
            wr_addr_q <= base_q + cnt_q[ADDR_W-1:0];
            wr_data_q <= s_data;
         end else begin
            wr_addr_q <= wr_addr_q;
            wr_data_q <= wr_data_q;
         end
      end
   end

   assign s_ready     = ready_s;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_len     = err_q;
   assign buf_wr_en   = wr_en_q;
   assign buf_wr_addr = wr_addr_q;
   assign buf_wr_data = wr_data_q;

endmodule
